// File: rtl/sd_pkg.sv
// Shared types and helpers for the sigma-delta decimation scheduler.
// Sequencer states and channel-index width helper.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sd_strobe_gen.sv
// Enable prescaler, OSR counter and settle counter.
// All strobes are registered from look-ahead next-state values.
module sd_strobe_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int OSR       = 16,
  parameter int SETTLE    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 en_o,
  output logic                 dec_o,
  output logic                 keep_o
);

  localparam int OW = $clog2(OSR);
  localparam int SW = $clog2(SETTLE + 1) + 1;
  localparam logic [OW-1:0] OSR_LAST = OW'(OSR - 1);
  localparam logic [SW-1:0] SET_N    = SW'(SETTLE);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [OW-1:0]        osr_q, osr_d;
  logic [SW-1:0]        set_q, set_d;
  logic                 en_q, en_d;
  logic                 dec_q, dec_d;
  logic                 keep_q, keep_d;

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    osr_d = osr_q;
    set_d = set_q;
    if (!run_i) begin
      cnt_d = '0;
      osr_d = '0;
      set_d = '0;
    end else if (load_i) begin
      div_d = div_i;
      cnt_d = '0;
      osr_d = '0;
      set_d = '0;
    end else begin
      cnt_d = (cnt_q == div_q) ? '0 : cnt_q + 1'b1;
      if (en_q)
        osr_d = (osr_q == OSR_LAST) ? '0 : osr_q + 1'b1;
      if (dec_q && set_q != SET_N)
        set_d = set_q + 1'b1;
    end
    // Strobes describe the cycle that follows this edge
    en_d   = run_i && (cnt_d == div_d);
    dec_d  = en_d && (osr_d == OSR_LAST);
    keep_d = dec_d && (set_d == SET_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      osr_q  <= '0;
      set_q  <= '0;
      en_q   <= 1'b0;
      dec_q  <= 1'b0;
      keep_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      osr_q  <= osr_d;
      set_q  <= set_d;
      en_q   <= en_d;
      dec_q  <= dec_d;
      keep_q <= keep_d;
    end
  end

  assign en_o   = en_q;
  assign dec_o  = dec_q;
  assign keep_o = keep_q;

endmodule

// File: rtl/sd_decim_scheduler.sv
// Sigma-delta receive sequencer: run/drain FSM, shadow bank
// and one-channel-per-beat valid/ready serialiser.
module sd_decim_scheduler
  import sd_pkg::*;
#(
  parameter  int CHANNELS  = 4,
  parameter  int WIDTH     = 16,
  parameter  int DIV_WIDTH = 8,
  parameter  int OSR       = 16,
  parameter  int SETTLE    = 3,
  localparam int CW        = chan_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic [DIV_WIDTH-1:0]      div,
  output logic                      en,
  output logic                      dec,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overrun,
  output logic                      busy
);

  state_e state_q, state_d;

  logic             load, run_nx;
  logic             en_s, dec_s, keep_s;
  logic             cap, beat, last;
  logic             valid_q, valid_d;
  logic [CW-1:0]    chan_q, chan_d, chan_nx;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] bank_q [CHANNELS];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (stop) state_d = DRAIN;
      DRAIN:   if (!valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load   = (state_q == IDLE) && start;
  assign run_nx = (state_d == RUN);

  sd_strobe_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .OSR       (OSR),
    .SETTLE    (SETTLE)
  ) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_nx),
    .load_i (load),
    .div_i  (div),
    .en_o   (en_s),
    .dec_o  (dec_s),
    .keep_o (keep_s)
  );

  always_comb begin
    cap     = keep_s && !valid_q;
    beat    = valid_q && out_ready;
    last    = (chan_q == CW'(CHANNELS - 1));
    chan_nx = chan_q + 1'b1;
    valid_d = valid_q;
    chan_d  = chan_q;
    data_d  = data_q;
    // A kept set arriving while a snapshot is still in flight is dropped
    ovr_d   = load ? 1'b0 : (ovr_q | (keep_s && valid_q));
    busy_d  = (state_d != IDLE);
    if (cap) begin
      valid_d = 1'b1;
      chan_d  = '0;
      data_d  = in_data[WIDTH-1:0];
    end else if (beat) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        chan_d = chan_nx;
        data_d = bank_q[chan_nx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < CHANNELS; k++)
        bank_q[k] <= in_data[k*WIDTH +: WIDTH];
    end
  end

  assign en        = en_s;
  assign dec       = dec_s;
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: doc/sd_decim_scheduler.md
# sd_decim_scheduler

Sequencer for the sigma-delta receive path. Generates the shared enable strobe for the second-order modulators, sinc3 decimators and magnitude estimators, and counts the oversampling ratio to mark decimation instants. At each instant it snapshots every channel's filter output and serialises the results, one channel per beat, onto a single valid/ready stream. It also discards the filter settling samples after start and flags overruns.

## Interface
Parameters:
- CHANNELS, 4, number of filter channels (≥1)
- WIDTH, 16, width of each channel result
- DIV_WIDTH, 8, width of the enable-rate divider
- OSR, 16, enable strobes per decimated sample (≥2)
- SETTLE, 3, decimated sample sets discarded after start (sinc3 order)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, active high & synchronous
- start  in  1  one-cycle request to begin; ignored unless IDLE
- stop  in  1  one-cycle request to end; ignored in IDLE
- div  in  DIV_WIDTH  enable period minus one; latched on accepted start
- en  out  1  enable strobe to modulators and filters
- dec  out  1  one-cycle decimation marker, coincident with an en pulse
- in_data  in  CHANNELS*WIDTH  filter outputs; channel k is bits [k*WIDTH +: WIDTH]
- out_data  out  WIDTH  serialised channel result
- out_chan  out  max(1,$clog2(CHANNELS))  channel index of out_data
- out_valid  out  1  out_data/out_chan valid
- out_ready  in  1  downstream accepts the beat
- overrun  out  1  sticky; a decimated set was dropped
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States:
  - IDLE: counters held at 0; en=0.
  - RUN: prescaler and decimator active.
  - DRAIN: en=0; finish serialising the current snapshot, then go to IDLE.
- IDLE→RUN on start: latch div, clear prescaler, decimation count, settle count and overrun.
- Prescaler counts 0..div_l. en=1 in the cycle the count equals div_l, then the count wraps to 0. div_l=0 gives en every cycle.
- Decimation counter advances on each en and wraps at OSR-1. dec=1 on the en pulse where the count equals OSR-1.
- Settle counter: the first SETTLE dec events are discarded. No snapshot is taken and overrun does not change.
- On a non-discarded dec:
  - If the serialiser is empty, capture all of in_data into the shadow bank in that cycle and begin serialising from channel 0.
  - If the serialiser is not empty, keep the shadow bank, drop the new set and set overrun.
- Serialiser: presents channels 0..CHANNELS-1 in order. A beat completes when out_valid&&out_ready. out_data and out_chan hold stable while out_valid&&!out_ready. After the last channel the serialiser is empty.
- stop in RUN: go to DRAIN on the next cycle. A dec coincident with stop is still honoured.
  - DRAIN with an empty serialiser goes to IDLE immediately, one cycle later.
- start while busy and stop while IDLE are ignored.
- rst at any point: all state to reset values; an in-progress set is lost and no partial stream continues.

## Timing
- Reset values: en=0, dec=0, out_valid=0, out_data=0, out_chan=0, overrun=0, busy=0.
- First en occurs div_l+1 cycles after the start cycle.
- en period is div_l+1 cycles; dec period is OSR*(div_l+1) cycles.
- Capture latency: out_valid rises the cycle after dec, with out_chan=0.
- Full-rate drain: with out_ready held high, channels are issued on consecutive cycles. The stream is empty CHANNELS cycles after out_valid rises.
- No overrun condition: the downstream must drain within OSR*(div_l+1) cycles.
- overrun is set the cycle after the offending dec. It clears only on rst or an accepted start.
- All outputs are registered.

## Structure
- Shared package sd_pkg:
  - state enum {IDLE, RUN, DRAIN}
  - function for channel-index width: max(1, clog2(CHANNELS))
- One sub-module, sd_strobe_gen: the prescaler, OSR counter and settle counter. It produces en, dec and dec_keep (dec with settling done).
- The top level holds the FSM, shadow bank and serialiser.

## Test plan
1. Rate: div=3, OSR=16, SETTLE=3, out_ready=1, start.
   - en every 4 cycles; dec every 64 cycles.
   - No out_valid before the 4th dec; then beats ch0..3 on four consecutive cycles.
2. Data mapping: in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111}.
   - Output beats (chan,data) are (0,1111), (1,2222), (2,3333), (3,4444).
3. Backpressure: out_ready low for 10 cycles after out_valid rises.
   - out_chan=0 and out_data stable throughout; then the remaining beats follow in order.
4. Overrun: out_ready=0 across two non-discarded dec events.
   - overrun=1 one cycle after the second dec.
   - Released stream carries the first snapshot's values.
   - overrun stays 1 until the next start.
5. Stop/drain: stop while ch1 is pending with out_ready=0.
   - en=0 from the next cycle; busy stays 1.
   - After out_ready=1, ch1..3 are delivered, then state is IDLE and busy=0.
6. Reset and edge cases:
   - rst mid-stream: all outputs 0 the next cycle.
   - div=0: en is high continuously in RUN.
   - start during RUN: no effect on counters.
